// File: rtl/bch_pkg.sv
// -----------------------------------------------------------------------------
// bch_pkg
// Shared definitions for the GF(2^13) BCH encoder.
//   GF_M        : field degree (13)
//   GF_PRIM     : primitive polynomial x^13 + x^4 + x^3 + x + 1
//   BCH_T       : correction capability (8)
//   BCH_R       : parity length, GF_M * BCH_T = 104
//   bch_state_e : encoder FSM states {IDLE, MSG, PAR}
//   BCH_GEN_T8  : low BCH_R coefficients of the monic generator g(x);
//                 the x^BCH_R term is implicit.
// -----------------------------------------------------------------------------
package bch_pkg;

    localparam int GF_M  = 13;
    localparam int BCH_T = 8;
    localparam int BCH_R = GF_M * BCH_T;

    localparam logic [GF_M:0]   GF_PRIM  = 14'h201B;
    localparam logic [GF_M-1:0] GF_ALPHA = 13'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2
    } bch_state_e;

    // Multiply two GF(2^13) elements (polynomial basis, reduced by GF_PRIM).
    function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a,
                                               input logic [GF_M-1:0] b);
        logic [GF_M-1:0] acc;
        logic [GF_M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < GF_M; i++) begin
            if (b[i]) acc = acc ^ sh;
            if (sh[GF_M-1]) sh = (sh << 1) ^ GF_PRIM[GF_M-1:0];
            else            sh = sh << 1;
        end
        return acc;
    endfunction

    // g(x) = product of the minimal polynomials of alpha^1, alpha^3 .. alpha^15.
    // 8191 is prime, so every conjugacy class has exactly 13 members and the
    // eight odd exponents give eight distinct degree-13 factors (degree 104).
    // Each minimal polynomial is built as prod_j (x + alpha^(i*2^j)); its
    // coefficients land in GF(2), so bit 0 of each coefficient is the value.
    function automatic logic [BCH_R-1:0] bch_gen_poly();
        logic [BCH_R:0]             g;
        logic [BCH_R:0]             prod;
        logic [GF_M:0][GF_M-1:0]    mp;
        logic [GF_M-1:0]            root;
        g    = '0;
        g[0] = 1'b1;
        for (int i = 1; i < 2 * BCH_T; i += 2) begin
            root    = '0;
            root[0] = 1'b1;
            for (int e = 0; e < i; e++) root = gf_mul(root, GF_ALPHA);
            mp    = '0;
            mp[0] = 13'd1;
            for (int j = 0; j < GF_M; j++) begin
                for (int k = GF_M; k > 0; k--) mp[k] = mp[k-1] ^ gf_mul(mp[k], root);
                mp[0] = gf_mul(mp[0], root);
                root  = gf_mul(root, root);
            end
            prod = '0;
            for (int k = 0; k <= GF_M; k++) begin
                if (mp[k][0]) prod = prod ^ (g << k);
            end
            g = prod;
        end
        return g[BCH_R-1:0];
    endfunction

    localparam logic [BCH_R-1:0] BCH_GEN_T8 = bch_gen_poly();

endpackage

// File: rtl/bch_lfsr_step.sv
// -----------------------------------------------------------------------------
// bch_lfsr_step
// Combinational next state of the systematic-encoder division LFSR after
// absorbing DW message bits (MSB first = highest degree).
//   i_state [R-1:0]  : current remainder
//   i_data  [DW-1:0] : message bits, bit DW-1 earliest
//   o_state [R-1:0]  : remainder after the DW bits
// -----------------------------------------------------------------------------
module bch_lfsr_step #(
    parameter int              R        = 104,
    parameter int              DW       = 8,
    parameter logic [R-1:0]    GEN_POLY = '0
) (
    input  logic [R-1:0]  i_state,
    input  logic [DW-1:0] i_data,
    output logic [R-1:0]  o_state
);

    logic [R-1:0] w_s;
    logic         w_fb;

    // Fully unrolled bit-serial division: each iteration is one shift of the
    // Galois LFSR with the feedback tap set equal to the generator.
    always_comb begin
        w_s  = i_state;
        w_fb = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            w_fb = i_data[i] ^ w_s[R-1];
            w_s  = {w_s[R-2:0], 1'b0} ^ ({R{w_fb}} & GEN_POLY);
        end
        o_state = w_s;
    end

endmodule

// File: rtl/bch_enc_stream.sv
// -----------------------------------------------------------------------------
// bch_enc_stream
// Streaming systematic BCH encoder. Message beats pass straight through with
// zero latency while the remainder m(x)*x^R mod g(x) is accumulated; then R/DW
// parity beats are appended.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready/in_sop   : message beat handshake, sop marks beat 0
//   in_data  [DW-1:0]          : message bits, bit DW-1 earliest
//   out_valid/out_ready        : codeword beat handshake
//   out_sop / out_eop          : first codeword beat / last parity beat
//   out_data [DW-1:0]          : codeword bits, same order as in_data
//   busy                       : frame in progress (MSG or PAR)
//   err                        : one-cycle pulse after a dropped non-sop beat
// -----------------------------------------------------------------------------
module bch_enc_stream
    import bch_pkg::*;
#(
    parameter int           K        = 4096,
    parameter int           R        = 104,
    parameter int           DW       = 8,
    parameter logic [R-1:0] GEN_POLY = bch_pkg::BCH_GEN_T8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sop,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sop,
    output logic          out_eop,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          err
);

    localparam int MSG_BEATS = K / DW;
    localparam int PAR_BEATS = R / DW;
    localparam int CW        = $clog2(MSG_BEATS + PAR_BEATS + 1);
    localparam logic [CW-1:0] LAST_MSG = CW'(MSG_BEATS - 1);
    localparam logic [CW-1:0] LAST_PAR = CW'(PAR_BEATS - 1);

    bch_state_e     r_state, w_state_next;
    logic [R-1:0]   r_lfsr, w_lfsr_next;
    logic [CW-1:0]  r_beat_cnt, w_cnt_next;
    logic           r_err;

    logic           w_start;
    logic [CW-1:0]  w_idx;
    logic [R-1:0]   w_step_base, w_step;
    logic           w_in_ready, w_out_valid, w_out_sop, w_out_eop;
    logic [DW-1:0]  w_out_data;

    // A sop beat always starts a fresh remainder, whether in IDLE or mid-frame.
    assign w_start     = in_valid & in_sop;
    assign w_step_base = w_start ? '0 : r_lfsr;
    // Message-beat index of the beat being presented (0 for a sop beat).
    assign w_idx       = in_sop ? '0 : r_beat_cnt;

    bch_lfsr_step #(
        .R        (R),
        .DW       (DW),
        .GEN_POLY (GEN_POLY)
    ) u_step (
        .i_state (w_step_base),
        .i_data  (in_data),
        .o_state (w_step)
    );

    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_cnt_next   = r_beat_cnt;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_out_sop    = 1'b0;
        w_out_eop    = 1'b0;
        w_out_data   = in_data;
        case (r_state)
            IDLE: begin
                // Non-sop beats are always swallowed; a sop beat is forwarded,
                // so it can only be taken when downstream accepts it.
                w_in_ready  = ~w_start | out_ready;
                w_out_valid = w_start;
                w_out_sop   = w_start;
                if (w_start && out_ready) begin
                    w_lfsr_next = w_step;
                    if (w_idx == LAST_MSG) begin
                        w_cnt_next   = '0;
                        w_state_next = PAR;
                    end else begin
                        w_cnt_next   = w_idx + CW'(1);
                        w_state_next = MSG;
                    end
                end
            end
            MSG: begin
                w_in_ready  = out_ready;
                w_out_valid = in_valid;
                w_out_sop   = w_start;
                if (in_valid && out_ready) begin
                    w_lfsr_next = w_step;
                    if (w_idx == LAST_MSG) begin
                        w_cnt_next   = '0;
                        w_state_next = PAR;
                    end else begin
                        w_cnt_next   = w_idx + CW'(1);
                    end
                end
            end
            PAR: begin
                w_out_valid = 1'b1;
                w_out_data  = r_lfsr[R-1 -: DW];
                w_out_eop   = (r_beat_cnt == LAST_PAR);
                if (out_ready) begin
                    if (r_beat_cnt == LAST_PAR) begin
                        w_lfsr_next  = '0;
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_lfsr_next  = r_lfsr << DW;
                        w_cnt_next   = r_beat_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_lfsr_next  = '0;
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lfsr     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_lfsr     <= w_lfsr_next;
            r_beat_cnt <= w_cnt_next;
            r_err      <= (r_state == IDLE) & in_valid & ~in_sop;
        end
    end

    // Combinational outputs are forced low while reset is held, so the
    // pass-through path cannot leak input activity during reset.
    assign in_ready  = rst_n & w_in_ready;
    assign out_valid = rst_n & w_out_valid;
    assign out_sop   = rst_n & w_out_sop;
    assign out_eop   = rst_n & w_out_eop;
    assign out_data  = rst_n ? w_out_data : '0;
    assign busy      = rst_n & (r_state != IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_bch_enc_stream.sv
module tb_bch_enc_stream;
    import bch_pkg::*;

    localparam int           SK  = 8;
    localparam int           SR  = 4;
    localparam int           SDW = 4;
    localparam logic [SR-1:0] SG = 4'b0011;
    localparam int           DK  = 4096;
    localparam int           DR  = 104;
    localparam int           DDW = 8;
    localparam int           DMB = DK / DDW;
    localparam int           DPB = DR / DDW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // small configuration DUT
    logic           s_in_valid = 1'b0, s_in_sop = 1'b0, s_out_ready = 1'b0;
    logic [SDW-1:0] s_in_data = '0;
    logic           s_in_ready, s_out_valid, s_out_sop, s_out_eop, s_busy, s_err;
    logic [SDW-1:0] s_out_data;

    // default configuration DUT
    logic           d_in_valid = 1'b0, d_in_sop = 1'b0, d_out_ready = 1'b1;
    logic [DDW-1:0] d_in_data = '0;
    logic           d_in_ready, d_out_valid, d_out_sop, d_out_eop, d_busy, d_err;
    logic [DDW-1:0] d_out_data;

    bch_enc_stream #(.K(SK), .R(SR), .DW(SDW), .GEN_POLY(SG)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sop(s_in_sop), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sop(s_out_sop),
        .out_eop(s_out_eop), .out_data(s_out_data), .busy(s_busy), .err(s_err)
    );

    bch_enc_stream dut_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_sop(d_in_sop), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_sop(d_out_sop),
        .out_eop(d_out_eop), .out_data(d_out_data), .busy(d_busy), .err(d_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // {out_valid, out_sop, out_eop, in_ready, busy, err, out_data}
    logic [9:0] s_stat;
    assign s_stat = {s_out_valid, s_out_sop, s_out_eop, s_in_ready, s_busy, s_err, s_out_data};

    typedef struct {
        logic [7:0] msg;
        logic [3:0] par;
    } vec_t;
    vec_t vecs [6];

    logic [7:0] dmsg [DMB];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Small-DUT status check; out_data is only meaningful while out_valid.
    task automatic chk_s(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {s_stat[9:4], s_out_valid ? s_out_data : 4'h0};
        chk(name, 128'(act), 128'(exp));
    endtask

    task automatic sdrive(input logic v, input logic sop, input logic [3:0] d, input logic ordy);
        @(negedge clk);
        s_in_valid  = v;
        s_in_sop    = sop;
        s_in_data   = d;
        s_out_ready = ordy;
        #1;
    endtask

    task automatic run_small(input logic [7:0] msg, input logic [3:0] par, input string tag);
        logic [7:0] m;
        m = msg;
        sdrive(1'b1, 1'b1, m[7:4], 1'b1);
        chk_s({tag, "_b0"}, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m[7:4]});
        sdrive(1'b1, 1'b0, m[3:0], 1'b1);
        chk_s({tag, "_b1"}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m[3:0]});
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        chk_s({tag, "_par"}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, par});
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        chk_s({tag, "_idle"}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
        $display("small frame %s msg=%02h expected parity=%h", tag, m, par);
    endtask

    // Textbook long division: remainder of p(x) by g(x) (x^R term implicit).
    function automatic logic [DR-1:0] mod_g(input logic [DK+DR-1:0] p_in);
        logic [DK+DR-1:0] p;
        p = p_in;
        for (int deg = DK + DR - 1; deg >= DR; deg--) begin
            if (p[deg]) p[deg -: DR+1] = p[deg -: DR+1] ^ {1'b1, BCH_GEN_T8};
        end
        return p[DR-1:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{msg: 8'h01, par: 4'h3};
        vecs[1] = '{msg: 8'h80, par: 4'hE};
        vecs[2] = '{msg: 8'h81, par: 4'hD};
        vecs[3] = '{msg: 8'h00, par: 4'h0};
        vecs[4] = '{msg: 8'hFF, par: 4'h4};
        vecs[5] = '{msg: 8'hA5, par: 4'hB};

        // Reset: every output low, even with a sop beat presented.
        #2;
        s_in_valid = 1'b1; s_in_sop = 1'b1; s_in_data = 4'h9; s_out_ready = 1'b1;
        #1;
        chk("reset_small", 128'(s_stat), 128'(0));
        chk("reset_dflt", 128'({d_in_ready, d_out_valid, d_busy, d_err}), 128'(0));
        $display("reset check done");
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        rst_n = 1'b1;
        #1;
        chk_s("post_reset_idle", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});

        for (int i = 0; i < 6; i++) run_small(vecs[i].msg, vecs[i].par, $sformatf("vec%0d", i));

        // Backpressure on message 0x80: 3 stalls mid-message, 2 in PAR.
        sdrive(1'b1, 1'b1, 4'h8, 1'b1);
        chk_s("stall_b0", {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h8});
        for (int i = 0; i < 3; i++) begin
            sdrive(1'b1, 1'b0, 4'h0, 1'b0);
            chk_s($sformatf("stall_msg%0d", i), {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0});
        end
        sdrive(1'b1, 1'b0, 4'h0, 1'b1);
        chk_s("stall_b1", {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0});
        for (int i = 0; i < 2; i++) begin
            sdrive(1'b0, 1'b0, 4'h0, 1'b0);
            chk_s($sformatf("stall_par%0d", i), {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hE});
        end
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        chk_s("stall_par_go", {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hE});
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        chk_s("stall_idle", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
        $display("stall frame msg=80 expected parity=e");

        // Stray beat in IDLE, then a frame restarted by a second sop.
        sdrive(1'b1, 1'b0, 4'h5, 1'b1);
        chk_s("drop_beat", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        chk_s("err_pulse", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0});
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        chk_s("err_clear", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
        sdrive(1'b1, 1'b1, 4'hF, 1'b1);
        chk_s("restart_first", {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF});
        sdrive(1'b1, 1'b1, 4'h8, 1'b1);
        chk_s("restart_sop", {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8});
        sdrive(1'b1, 1'b0, 4'h0, 1'b1);
        chk_s("restart_b1", {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0});
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        chk_s("restart_par", {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hE});
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        $display("drop+restart frame msg=80 expected parity=e");

        // Reset during PAR aborts the frame with no residue.
        sdrive(1'b1, 1'b1, 4'h8, 1'b1);
        sdrive(1'b1, 1'b0, 4'h1, 1'b1);
        sdrive(1'b0, 1'b0, 4'h0, 1'b0);
        chk_s("pre_reset_par", {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hD});
        @(negedge clk);
        rst_n = 1'b0;
        s_in_valid = 1'b1; s_in_sop = 1'b1; s_in_data = 4'h7; s_out_ready = 1'b1;
        #1;
        chk("reset_in_par", 128'(s_stat), 128'(0));
        sdrive(1'b0, 1'b0, 4'h0, 1'b1);
        rst_n = 1'b1;
        $display("reset during parity applied");
        run_small(8'h01, 4'h3, "after_reset");

        // Default configuration: 100 random messages back-to-back.
        for (int f = 0; f < 100; f++) begin
            logic [DR-1:0]    exp_par;
            logic [DR-1:0]    got_par;
            logic [DK+DR-1:0] poly;
            int               bad;
            bad = 0;
            for (int n = 0; n < DMB; n++) dmsg[n] = 8'($urandom);
            for (int n = 0; n < DMB; n++) begin
                @(negedge clk);
                d_in_valid = 1'b1;
                d_in_sop = (n == 0);
                d_in_data = dmsg[n];
                d_out_ready = 1'b1;
                #1;
                if (!(d_out_valid && (d_out_sop == (n == 0)) && !d_out_eop && d_in_ready
                      && d_out_data == dmsg[n])) bad++;
            end
            got_par = '0;
            for (int p = 0; p < DPB; p++) begin
                @(negedge clk);
                d_in_valid = 1'b0;
                d_in_sop = 1'b0;
                d_in_data = 8'h00;
                #1;
                if (!(d_out_valid && (d_out_eop == (p == DPB - 1)) && !d_in_ready && d_busy))
                    bad++;
                got_par[DR-1-8*p -: 8] = d_out_data;
            end
            poly = '0;
            for (int n = 0; n < DMB; n++) poly[DK+DR-1-8*n -: 8] = dmsg[n];
            exp_par = mod_g(poly);
            poly[DR-1:0] = got_par;
            chk($sformatf("dflt%0d_parity", f), 128'(got_par), 128'(exp_par));
            chk($sformatf("dflt%0d_remainder", f), 128'(mod_g(poly)), 128'(0));
            chk($sformatf("dflt%0d_framing", f), 128'(bad), 128'(0));
            $display("default frame %0d parity=%h", f, got_par);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
